// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared 512x16 main memory.
// Four cache controllers compete for one serialized read or write slot.
// A grant is latched in IDLE, the memory is accessed in ACCESS after
// MEM_LAT wait cycles, and DONE pulses ack back to the granted requester.
module mem_bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [9*NREQ-1:0]    addr,
    input  logic [16*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]      ack,
    output logic [15:0]          rdata,
    output logic                 busy,
    output logic [1:0]           grant_id,
    output logic [8:0]           mem_address_read,
    input  logic [15:0]          mem_readed,
    output logic                 mem_write,
    output logic [8:0]           mem_address_write,
    output logic [15:0]          mem_data_write
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  id;
    logic [1:0]  last;
    logic [1:0]  sel;
    logic [1:0]  idx;
    logic        sel_valid;
    logic [2:0]  cnt;
    logic        lat_we;
    logic [8:0]  lat_addr;
    logic [15:0] lat_wdata;

    // Round-robin pick: first requesting index after the last one served.
    always_comb begin
        sel       = '0;
        idx       = '0;
        sel_valid = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!sel_valid && req[idx]) begin
                sel       = idx;
                sel_valid = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus state-derived ack, write strobe and busy.
    always_comb begin
        state_nxt = state;
        ack       = '0;
        mem_write = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    mem_write = lat_we;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ack[id]   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant latch, wait counter, read capture and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id        <= '0;
            last      <= 2'd3;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_valid) begin
                        id        <= sel;
                        cnt       <= LAT_INIT;
                        lat_we    <= we[sel];
                        lat_addr  <= addr[9*sel +: 9];
                        lat_wdata <= wdata[16*sel +: 16];
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 3'd1;
                    end else if (!lat_we) begin
                        rdata <= mem_readed;
                    end
                end
                DONE: begin
                    last <= id;
                end
                default: begin
                end
            endcase
        end
    end

    assign grant_id          = id;
    assign mem_address_read  = lat_addr;
    assign mem_address_write = lat_addr;
    assign mem_data_write    = lat_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a behavioural memory, a
// transaction-level round-robin reference model, directed scenarios and a
// randomized phase. A second instance is built with MEM_LAT=0.
module tb_mem_bus_arbiter;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  tb_we;
    logic [8:0]  tb_addr  [4];
    logic [15:0] tb_wdata [4];
    logic [35:0] addr;
    logic [63:0] wdata;
    logic [3:0]  ack;
    logic [15:0] rdata;
    logic        busy;
    logic [1:0]  grant_id;
    logic [8:0]  mem_address_read;
    logic [15:0] mem_readed;
    logic        mem_write;
    logic [8:0]  mem_address_write;
    logic [15:0] mem_data_write;

    // second instance, zero extra latency
    logic        z_rst_n;
    logic [3:0]  z_req;
    logic [3:0]  z_ack;
    logic [15:0] z_rdata;
    logic        z_busy;
    logic [1:0]  z_grant_id;
    logic [8:0]  z_mem_address_read;
    logic [15:0] z_mem_readed;
    logic        z_mem_write;
    logic [8:0]  z_mem_address_write;
    logic [15:0] z_mem_data_write;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // memory environment and reference model state
    logic [15:0] mem     [512];
    logic [15:0] ref_mem [512];
    logic        mem_ready = 1'b0;
    logic        bd_we     = 1'b0;
    logic [8:0]  bd_addr   = '0;
    logic [15:0] bd_data   = '0;
    int          m_last;
    logic [15:0] m_rdata;
    int          last_ack_cyc;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign addr  = {tb_addr[3], tb_addr[2], tb_addr[1], tb_addr[0]};
    assign wdata = {tb_wdata[3], tb_wdata[2], tb_wdata[1], tb_wdata[0]};

    function automatic logic [15:0] init_val(input int i);
        return 16'((i * 16'h0101) ^ 16'h5A3C);
    endfunction

    // behavioural 512x16 memory: combinational read, write on posedge
    assign mem_readed = mem[mem_address_read];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (mem_write) begin
            mem[mem_address_write] <= mem_data_write;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end
    end

    assign z_mem_readed = 16'hA5A5 ^ {7'd0, z_mem_address_read};

    mem_bus_arbiter #(.NREQ(4), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(tb_we), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy),
        .grant_id(grant_id), .mem_address_read(mem_address_read),
        .mem_readed(mem_readed), .mem_write(mem_write),
        .mem_address_write(mem_address_write), .mem_data_write(mem_data_write)
    );

    mem_bus_arbiter #(.NREQ(4), .MEM_LAT(0)) dut_z (
        .clk(clk), .reset_n(z_rst_n), .req(z_req), .we(4'b0000),
        .addr({27'd0, 9'd7}), .wdata(64'd0), .ack(z_ack), .rdata(z_rdata),
        .busy(z_busy), .grant_id(z_grant_id),
        .mem_address_read(z_mem_address_read), .mem_readed(z_mem_readed),
        .mem_write(z_mem_write), .mem_address_write(z_mem_address_write),
        .mem_data_write(z_mem_data_write)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference arbitration rule: scan last+1, last+2, ... modulo 4
    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // One transaction through the DUT, checked against the model.
    // mode 0: inputs held, 1: granted requester drops req, 2: inputs scrambled
    task automatic serve(input int mode);
        int          id;
        int          n;
        int          pulses;
        bit          got;
        logic        w;
        logic [8:0]  a;
        logic [15:0] d;
        logic [15:0] r_at_ack;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("idle_before_grant", busy, 0);
        id = pick(req, m_last);
        if (id < 0) begin
            $display("FAIL serve: bench issued no request");
            $fatal(1);
        end
        w = tb_we[id]; a = tb_addr[id]; d = tb_wdata[id];
        n = 0; pulses = 0; got = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1; n++;
            if (n == 1) begin
                check("grant_id_access", grant_id, id);
                if (mode == 1) req[id] = 1'b0;
                if (mode == 2) begin
                    req   = 4'($urandom);
                    tb_we = 4'($urandom);
                    for (int i = 0; i < 4; i++) begin
                        tb_addr[i]  = 9'($urandom);
                        tb_wdata[i] = 16'($urandom);
                    end
                end
            end
            if (mem_write === 1'b1) begin
                pulses++;
                check("wr_addr", mem_address_write, a);
                check("wr_data", mem_data_write, d);
            end
            if (ack !== 4'b0000) got = 1;
            else check("busy_in_txn", busy, 1);
        end
        check("ack_latency", n, LAT + 2);
        check("ack_onehot", ack, 32'(1 << id));
        check("grant_id_done", grant_id, id);
        if (w) begin
            ref_mem[a] = d;
            check("wr_pulses", pulses, 1);
            check("mem_commit", mem[a], d);
        end else begin
            m_rdata = ref_mem[a];
            check("rd_no_write", pulses, 0);
        end
        check("rdata", rdata, m_rdata);
        m_last = id;
        last_ack_cyc = cyc;
        r_at_ack = rdata;
        @(posedge clk); #1;
        check("ack_single_cycle", ack, 0);
        check("rdata_hold", rdata, r_at_ack);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          prev;
        int          nack;
        int          t0;
        logic [15:0] v;
        logic [1:0]  exp_order [5];

        reset_n = 1'b0;
        z_rst_n = 1'b0;
        z_req   = 4'b0000;
        req     = 4'b0000;
        tb_we   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tb_addr[i]  = 9'(i);
            tb_wdata[i] = '0;
        end
        for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
        m_last  = 3;
        m_rdata = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_addr_rd", mem_address_read, 0);
        check("rst_addr_wr", mem_address_write, 0);
        check("rst_data_wr", mem_data_write, 0);

        // all four requesting from reset: order 0,1,2,3,0, acks 4 apart
        req = 4'b1111;
        reset_n = 1'b1;
        z_rst_n = 1'b1;
        exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd2;
        exp_order[3] = 2'd3; exp_order[4] = 2'd0;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            serve(0);
            check("rr_order", grant_id, exp_order[k]);
            if (k > 0) check("rr_spacing", last_ack_cyc - prev, LAT + 3);
            prev = last_ack_cyc;
        end
        req = 4'b0000;

        // single read of mem[5]=0003 by requester 0
        bd_we = 1'b1; bd_addr = 9'd5; bd_data = 16'h0003;
        @(posedge clk); #1;
        bd_we = 1'b0;
        ref_mem[5] = 16'h0003;
        tb_we[0] = 1'b0; tb_addr[0] = 9'd5;
        req = 4'b0001;
        serve(0);
        check("t1_rdata", rdata, 16'h0003);

        // requester 2 writes BEEF to 256, requester 1 reads it back
        tb_we[2] = 1'b1; tb_addr[2] = 9'd256; tb_wdata[2] = 16'hBEEF;
        req = 4'b0100;
        serve(0);
        check("t2_mem256", mem[256], 16'hBEEF);
        tb_we[1] = 1'b0; tb_addr[1] = 9'd256;
        req = 4'b0010;
        serve(0);
        check("t2_readback", rdata, 16'hBEEF);

        // requester 3 drops req during a write; it must still commit and ack
        tb_we[3] = 1'b1; tb_addr[3] = 9'd34; tb_wdata[3] = 16'h00FF;
        req = 4'b1000;
        serve(1);
        check("t4_mem34", mem[34], 16'h00FF);
        check("t4_grant", grant_id, 3);

        // reset asserted in the committing ACCESS cycle of a write to 35
        v = mem[35];
        tb_we[0] = 1'b1; tb_addr[0] = 9'd35; tb_wdata[0] = 16'hDEAD;
        req = 4'b0001;
        @(posedge clk); #1;
        check("t5_access", busy, 1);
        @(posedge clk); #1;
        check("t5_wr_strobe", mem_write, 1);
        reset_n = 1'b0;
        #1;
        check("t5_wr_drop", mem_write, 0);
        check("t5_busy_drop", busy, 0);
        check("t5_no_ack", ack, 0);
        @(posedge clk); #1;
        check("t5_mem35_kept", mem[35], v);
        check("t5_no_ack_late", ack, 0);
        tb_we[1] = 1'b0; tb_addr[1] = 9'd35;
        req = 4'b1010;
        reset_n = 1'b1;
        m_last  = 3;
        m_rdata = '0;
        check("t5_rdata_rst", rdata, 0);
        serve(0);
        check("t5_first_grant", grant_id, 1);
        check("t5_read35", rdata, v);

        // randomized traffic against the reference model
        for (int t = 0; t < 40; t++) begin
            req   = 4'($urandom_range(1, 15));
            tb_we = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                tb_addr[i]  = 9'($urandom_range(0, 15));
                tb_wdata[i] = 16'($urandom);
            end
            serve(int'($urandom_range(0, 2)));
        end
        req = 4'b0000;
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

        // MEM_LAT=0 instance: back-to-back reads of address 7 by requester 0
        t0 = cyc; prev = 0; nack = 0;
        z_req = 4'b0001;
        for (int n = 0; n < 15 && nack < 3; n++) begin
            @(posedge clk); #1;
            if (z_ack !== 4'b0000) begin
                check("z_ack", z_ack, 4'b0001);
                check("z_rdata", z_rdata, 16'hA5A5 ^ 16'h0007);
                if (nack == 0) check("z_first_latency", cyc - t0, 2);
                else check("z_spacing", cyc - prev, 3);
                prev = cyc;
                nack++;
            end
        end
        check("z_ack_count", nack, 3);
        z_req = 4'b0000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
